wait_event_ctrl: RTL and testbench

//  Parametrised multi-channel wait-event engine for the HDL generic testbench.
//  The sequencer issues one wait command at a time: channel, mode, mask/value and timeout.
//  The block watches the selected channel of a packed signal bus and returns a single

---
 rtl/wait_event_ctrl.sv | 179 +++++++++++++++++
 tb/tb_wait_event_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wait_event_ctrl.sv
// Multi-channel wait-event engine: accepts one wait command, watches a channel of a
// packed signal bus for an edge/level/change condition, and returns status plus elapsed cycles.
module wait_event_ctrl #(
    parameter int  CH_NB     = 5,
    parameter int  CH_WIDTH  = 32,
    parameter int  TMO_WIDTH = 32,
    localparam int CH_SEL_W  = (CH_NB > 1) ? $clog2(CH_NB) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CH_NB*CH_WIDTH-1:0] wait_signals,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [CH_SEL_W-1:0]       cmd_ch,
    input  logic [2:0]                cmd_mode,
    input  logic [CH_WIDTH-1:0]       cmd_mask,
    input  logic [CH_WIDTH-1:0]       cmd_value,
    input  logic [TMO_WIDTH-1:0]      cmd_timeout,
    input  logic                      abort,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [1:0]                rsp_status,
    output logic [TMO_WIDTH-1:0]      rsp_cycles,
    output logic                      busy
);

    localparam logic [2:0] MODE_RISE    = 3'd0;
    localparam logic [2:0] MODE_FALL    = 3'd1;
    localparam logic [2:0] MODE_LVL_EQ  = 3'd2;
    localparam logic [2:0] MODE_LVL_NEQ = 3'd3;
    localparam logic [2:0] MODE_CHANGE  = 3'd4;

    localparam logic [1:0] ST_MATCH   = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ERROR   = 2'b10;
    localparam logic [1:0] ST_ABORTED = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [CH_SEL_W-1:0]    ch_reg, ch_next;
    logic [2:0]             mode_reg, mode_next;
    logic [CH_WIDTH-1:0]    mask_reg, mask_next;
    logic [CH_WIDTH-1:0]    value_reg, value_next;
    logic [TMO_WIDTH-1:0]   timeout_reg, timeout_next;
    logic [CH_WIDTH-1:0]    prev_reg, prev_next;
    logic [TMO_WIDTH-1:0]   cnt_reg, cnt_next;
    logic [1:0]             status_reg, status_next;
    logic [TMO_WIDTH-1:0]   cycles_reg, cycles_next;

    logic [CH_WIDTH-1:0]    chans [CH_NB];
    logic [CH_WIDTH-1:0]    cmd_chan;
    logic [CH_WIDTH-1:0]    wait_chan;
    logic [CH_WIDTH-1:0]    sample;
    logic                   hit;
    logic                   tmo_hit;
    logic                   cmd_bad;

    for (genvar gi = 0; gi < CH_NB; gi++) begin : g_chan
        assign chans[gi] = wait_signals[gi*CH_WIDTH +: CH_WIDTH];
    end

    // Out-of-range indices select nothing; such commands are rejected as ERROR anyway.
    always_comb begin
        cmd_chan  = '0;
        wait_chan = '0;
        for (int i = 0; i < CH_NB; i++) begin
            if (cmd_ch == CH_SEL_W'(i)) cmd_chan  = chans[i];
            if (ch_reg == CH_SEL_W'(i)) wait_chan = chans[i];
        end
    end

    assign cmd_bad = ({1'b0, cmd_ch} >= (CH_SEL_W+1)'(CH_NB)) || (cmd_mode > MODE_CHANGE);
    assign sample  = wait_chan & mask_reg;
    assign tmo_hit = (timeout_reg != '0) && (cnt_reg == timeout_reg - TMO_WIDTH'(1));

    always_comb begin
        hit = 1'b0;
        case (mode_reg)
            MODE_RISE:    hit = |(~prev_reg & sample);
            MODE_FALL:    hit = |(prev_reg & ~sample);
            MODE_LVL_EQ:  hit = (sample == (value_reg & mask_reg));
            MODE_LVL_NEQ: hit = (sample != (value_reg & mask_reg));
            MODE_CHANGE:  hit = (sample != prev_reg);
            default:      hit = 1'b0;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        ch_next      = ch_reg;
        mode_next    = mode_reg;
        mask_next    = mask_reg;
        value_next   = value_reg;
        timeout_next = timeout_reg;
        prev_next    = prev_reg;
        cnt_next     = cnt_reg;
        status_next  = status_reg;
        cycles_next  = cycles_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    ch_next      = cmd_ch;
                    mode_next    = cmd_mode;
                    mask_next    = cmd_mask;
                    value_next   = cmd_value;
                    timeout_next = cmd_timeout;
                    prev_next    = cmd_chan & cmd_mask;
                    cnt_next     = '0;
                    if (cmd_bad) begin
                        state_next  = RESP;
                        status_next = ST_ERROR;
                        cycles_next = '0;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                prev_next = sample;
                cnt_next  = (&cnt_reg) ? cnt_reg : cnt_reg + TMO_WIDTH'(1);
                if (abort) begin
                    state_next  = RESP;
                    status_next = ST_ABORTED;
                    cycles_next = cnt_reg;
                end else if (hit) begin
                    state_next  = RESP;
                    status_next = ST_MATCH;
                    cycles_next = cnt_reg;
                end else if (tmo_hit) begin
                    state_next  = RESP;
                    status_next = ST_TIMEOUT;
                    cycles_next = timeout_reg;
                end
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            ch_reg      <= '0;
            mode_reg    <= '0;
            mask_reg    <= '0;
            value_reg   <= '0;
            timeout_reg <= '0;
            prev_reg    <= '0;
            cnt_reg     <= '0;
            status_reg  <= '0;
            cycles_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            ch_reg      <= ch_next;
            mode_reg    <= mode_next;
            mask_reg    <= mask_next;
            value_reg   <= value_next;
            timeout_reg <= timeout_next;
            prev_reg    <= prev_next;
            cnt_reg     <= cnt_next;
            status_reg  <= status_next;
            cycles_reg  <= cycles_next;
        end
    end

    assign cmd_ready  = (state_reg == IDLE);
    assign busy       = (state_reg != IDLE);
    assign rsp_valid  = (state_reg == RESP);
    assign rsp_status = status_reg;
    assign rsp_cycles = cycles_reg;

endmodule

// File: tb/tb_wait_event_ctrl.sv
// Directed bench for wait_event_ctrl: edge, level, change, timeout, error, abort,
// async reset and response back-pressure, each with hand-computed expectations.
module tb_wait_event_ctrl;

    localparam int CH_NB = 5;
    localparam int CW    = 32;
    localparam int TW    = 32;
    localparam int SW    = 3;

    logic              clk;
    logic              rst;
    logic [CH_NB*CW-1:0] wait_signals;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [SW-1:0]     cmd_ch;
    logic [2:0]        cmd_mode;
    logic [CW-1:0]     cmd_mask;
    logic [CW-1:0]     cmd_value;
    logic [TW-1:0]     cmd_timeout;
    logic              abort;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_status;
    logic [TW-1:0]     rsp_cycles;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    wait_event_ctrl #(.CH_NB(CH_NB), .CH_WIDTH(CW), .TMO_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .wait_signals(wait_signals),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
        .cmd_mode(cmd_mode), .cmd_mask(cmd_mask), .cmd_value(cmd_value),
        .cmd_timeout(cmd_timeout), .abort(abort), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_cycles(rsp_cycles),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [31:0] v);
        wait_signals[c*CW +: CW] = v;
    endtask

    // Presents a command for one accepting edge; returns 1 time unit after that edge.
    task automatic issue(input logic [SW-1:0] ch, input logic [2:0] mode,
                         input logic [31:0] mask, input logic [31:0] value,
                         input logic [31:0] tmo);
        cmd_ch      = ch;
        cmd_mode    = mode;
        cmd_mask    = mask;
        cmd_value   = value;
        cmd_timeout = tmo;
        cmd_valid   = 1'b1;
        step();
        cmd_valid   = 1'b0;
        $display("cmd ch=%0d mode=%0d mask=%h value=%h tmo=%0d", ch, mode, mask, value, tmo);
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] st, input logic [31:0] cyc);
        check({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
        check({tag, "_status"}, {30'b0, rsp_status}, {30'b0, st});
        check({tag, "_cycles"}, rsp_cycles, cyc);
        $display("rsp %s status=%0d cycles=%0d", tag, rsp_status, rsp_cycles);
    endtask

    initial begin
        rst = 1'b1; wait_signals = '0; cmd_valid = 1'b0; cmd_ch = '0; cmd_mode = '0;
        cmd_mask = '0; cmd_value = '0; cmd_timeout = '0; abort = 1'b0; rsp_ready = 1'b1;
        #1;
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_status", {30'b0, rsp_status}, 32'd0);
        check("rst_cycles", rsp_cycles, 32'd0);
        step(); step();
        rst = 1'b0;
        step();

        // 1: RISE on ch2 bit0, signal rises so that it is first seen at cnt=4
        issue(3'd2, 3'd0, 32'h1, 32'h0, 32'd0);
        check("t1_busy", {31'b0, busy}, 32'd1);
        step(); step(); step(); step();
        set_ch(2, 32'h1);
        check("t1_not_yet", {31'b0, rsp_valid}, 32'd0);
        step();
        check_rsp("t1", 2'b00, 32'd4);
        step();
        check("t1_idle", {31'b0, cmd_ready}, 32'd1);

        // 2: level already true -> response one cycle after accept
        set_ch(0, 32'hCAFEDECA);
        issue(3'd0, 3'd2, 32'hFFFF_FFFF, 32'hCAFEDECA, 32'd0);
        check("t2_wait", {31'b0, rsp_valid}, 32'd0);
        step();
        check_rsp("t2", 2'b00, 32'd0);
        step();

        // 3: FALL never happens, timeout=10 fires when cnt reaches 9
        set_ch(1, 32'h1);
        issue(3'd1, 3'd1, 32'h1, 32'h0, 32'd10);
        for (int i = 0; i < 9; i++) step();
        check("t3_not_yet", {31'b0, rsp_valid}, 32'd0);
        step();
        check_rsp("t3", 2'b01, 32'd10);
        step();

        // 4: invalid channel and invalid mode go straight to ERROR
        issue(3'd7, 3'd0, 32'h1, 32'h0, 32'd0);
        check_rsp("t4ch", 2'b10, 32'd0);
        step();
        check("t4ch_idle", {31'b0, busy}, 32'd0);
        issue(3'd0, 3'd6, 32'h1, 32'h0, 32'd0);
        check_rsp("t4mode", 2'b10, 32'd0);
        step();

        // mask=0 edge wait never hits even while the channel toggles
        issue(3'd2, 3'd0, 32'h0, 32'h0, 32'd2);
        set_ch(2, 32'h0);
        step();
        set_ch(2, 32'h1);
        check("t4m0_not_yet", {31'b0, rsp_valid}, 32'd0);
        step();
        check_rsp("t4m0", 2'b01, 32'd2);
        step();

        // 5: CHANGE with abort and a change in the same cycle at cnt=3
        set_ch(3, 32'h55);
        issue(3'd3, 3'd4, 32'hFFFF_FFFF, 32'h0, 32'd0);
        step(); step(); step();
        check("t5_not_yet", {31'b0, rsp_valid}, 32'd0);
        abort = 1'b1;
        set_ch(3, 32'hAA);
        step();
        abort = 1'b0;
        check_rsp("t5", 2'b11, 32'd3);
        step();

        // 5b: asynchronous reset in the middle of a wait
        issue(3'd3, 3'd4, 32'hFFFF_FFFF, 32'h0, 32'd0);
        step(); step();
        check("t5r_busy_before", {31'b0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5r_busy", {31'b0, busy}, 32'd0);
        check("t5r_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("t5r_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("t5r_cycles", rsp_cycles, 32'd0);
        $display("async reset mid-wait applied");
        #1 rst = 1'b0;
        step();

        // 6: back-pressure on the response, then a follow-up command
        rsp_ready = 1'b0;
        set_ch(4, 32'h1);
        issue(3'd4, 3'd2, 32'hF, 32'h2, 32'd3);
        step(); step(); step();
        check_rsp("t6", 2'b01, 32'd3);
        set_ch(4, 32'h2);
        for (int i = 0; i < 4; i++) begin
            step();
            check_rsp("t6_hold", 2'b01, 32'd3);
            check("t6_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        end
        rsp_ready   = 1'b1;
        cmd_valid   = 1'b1;
        cmd_ch      = 3'd4;
        cmd_mode    = 3'd2;
        cmd_mask    = 32'hF;
        cmd_value   = 32'h2;
        cmd_timeout = 32'd0;
        step();
        check("t6_released_valid", {31'b0, rsp_valid}, 32'd0);
        check("t6_released_ready", {31'b0, cmd_ready}, 32'd1);
        check("t6_released_busy", {31'b0, busy}, 32'd0);
        step();
        cmd_valid = 1'b0;
        check("t6_accepted", {31'b0, busy}, 32'd1);
        check("t6_accepted_ready", {31'b0, cmd_ready}, 32'd0);
        step();
        check_rsp("t6_next", 2'b00, 32'd0);
        step();
        check("t6_end_idle", {31'b0, cmd_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
